// File: rtl/fetch_sequencer.sv
// Fetch controller for the 4-bit computer: sequences opcode/arg/RAM reads
// through the ROM/RAM mux and issues instructions to execute via valid/ready.
// Optional build macro: FETCH_SEQ_JUMP_EN (JMP_OP redirects the PC and is never issued).
module fetch_sequencer #(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 4,
    parameter logic [DATA_W-1:0] HALT_OP = 4'hF,
    parameter logic [DATA_W-1:0] JMP_OP  = 4'h7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mux_sel,
    output logic              mux_en,
    input  logic [DATA_W-1:0] mux_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] operand,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic              halted
);

`ifdef FETCH_SEQ_JUMP_EN
    localparam logic JUMP_EN = 1'b1;
`else
    localparam logic JUMP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH_OP  = 3'd1,
        S_FETCH_ARG = 3'd2,
        S_FETCH_RAM = 3'd3,
        S_ISSUE     = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              exec_valid_q;
    logic              halted_q;
    logic              jmp_hit;
    logic              accept;

    assign jmp_hit = JUMP_EN && (instr_q == JMP_OP);
    assign accept  = exec_ready;

    // State, datapath and Moore flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            ram_addr_q   <= '0;
            instr_q      <= '0;
            operand_q    <= '0;
            exec_valid_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ram_addr_q   <= ram_addr_d;
            instr_q      <= instr_d;
            operand_q    <= operand_d;
            exec_valid_q <= (state_d == S_ISSUE);
            halted_q     <= (state_d == S_HALT);
        end
    end

    // Next state and the captures performed in each fetch step
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ram_addr_d = ram_addr_q;
        instr_d    = instr_q;
        operand_d  = operand_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH_OP;
            end
            S_FETCH_OP: begin
                instr_d = mux_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_FETCH_ARG;
            end
            S_FETCH_ARG: begin
                if (jmp_hit) begin
                    pc_d    = ADDR_W'(mux_data);
                    state_d = run ? S_FETCH_OP : S_IDLE;
                end else if (instr_q[DATA_W-1]) begin
                    pc_d       = pc_q + ADDR_W'(1);
                    ram_addr_d = ADDR_W'(mux_data);
                    state_d    = S_FETCH_RAM;
                end else begin
                    pc_d      = pc_q + ADDR_W'(1);
                    operand_d = mux_data;
                    state_d   = S_ISSUE;
                end
            end
            S_FETCH_RAM: begin
                operand_d = mux_data;
                state_d   = S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    if (instr_q == HALT_OP) state_d = S_HALT;
                    else if (run)           state_d = S_FETCH_OP;
                    else                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Mux control decoded from the current state
    always_comb begin
        mux_en  = 1'b0;
        mux_sel = 1'b0;
        unique case (state_q)
            S_FETCH_OP:  mux_en = 1'b1;
            S_FETCH_ARG: mux_en = 1'b1;
            S_FETCH_RAM: begin
                mux_en  = 1'b1;
                mux_sel = 1'b1;
            end
            default: begin
                mux_en  = 1'b0;
                mux_sel = 1'b0;
            end
        endcase
    end

    assign rom_addr   = pc_q;
    assign ram_addr   = ram_addr_q;
    assign instr      = instr_q;
    assign operand    = operand_q;
    assign exec_valid = exec_valid_q;
    assign halted     = halted_q;

endmodule
